// File: rtl/logic16_rr_arbiter_if.sv
// Requester-side bus of the shared 16-bit logic unit arbiter: per-requester
// request/operand lanes plus the grant/result return path.
interface logic16_rr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  localparam int IDW  = $clog2(NREQ)
);
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] op_a;
  logic [NREQ*WIDTH-1:0] op_b;
  logic [NREQ*2-1:0]     opcode;
  logic [NREQ-1:0]       gnt;
  logic                  busy;
  logic                  res_valid;
  logic [WIDTH-1:0]      res_data;
  logic [IDW-1:0]        res_id;

  modport master (
    output req, op_a, op_b, opcode,
    input  gnt, busy, res_valid, res_data, res_id
  );

  modport slave (
    input  req, op_a, op_b, opcode,
    output gnt, busy, res_valid, res_data, res_id
  );
endinterface

// File: rtl/logic16_rr_arbiter.sv
// Round-robin sequencer sharing one bitwise NOT/AND/OR/XOR unit among NREQ requesters.
// Define LOGIC16_ARB_STATS_EN to add the op_count completed-operation counter port.
//
// state | meaning
// IDLE  | no op in flight; arbitrate on req, latch winner's operands
// EXEC  | compute result from latched operands, grant held
// RESP  | res_valid strobe for one cycle, grant held
module logic16_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic clk,
  input  logic reset,
`ifdef LOGIC16_ARB_STATS_EN
  output logic [15:0] op_count,
`endif
  logic16_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [1:0] OP_NOT = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  state_t            state_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [IDW-1:0]    win_q;
  logic [NREQ-1:0]   gnt_q;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [1:0]        opc_q;
  logic              res_valid_q;
  logic [WIDTH-1:0]  res_data_q;
  logic [IDW-1:0]    res_id_q;

  logic [IDW-1:0]    win_d;
  logic              found_d;
  logic [WIDTH-1:0]  result_d;

  // Search starts just after the last winner so every requester gets a turn.
  always_comb begin
    win_d   = '0;
    found_d = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found_d && bus.req[(int'(rr_ptr_q) + k) % NREQ]) begin
        found_d = 1'b1;
        win_d   = IDW'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    result_d = '0;
    case (opc_q)
      OP_NOT:  result_d = ~a_q;
      OP_AND:  result_d = a_q & b_q;
      OP_OR:   result_d = a_q | b_q;
      OP_XOR:  result_d = a_q ^ b_q;
      default: result_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= IDW'(NREQ - 1);
      win_q       <= '0;
      gnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      opc_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          res_valid_q <= 1'b0;
          if (found_d) begin
            a_q      <= bus.op_a[int'(win_d)*WIDTH +: WIDTH];
            b_q      <= bus.op_b[int'(win_d)*WIDTH +: WIDTH];
            opc_q    <= bus.opcode[int'(win_d)*2 +: 2];
            win_q    <= win_d;
            rr_ptr_q <= win_d;
            gnt_q    <= NREQ'(1) << win_d;
            state_q  <= EXEC;
          end else begin
            gnt_q <= '0;
          end
        end
        EXEC: begin
          res_data_q  <= result_d;
          res_id_q    <= win_q;
          res_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          res_valid_q <= 1'b0;
          gnt_q       <= '0;
          state_q     <= IDLE;
        end
        default: begin
          res_valid_q <= 1'b0;
          gnt_q       <= '0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;

`ifdef LOGIC16_ARB_STATS_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_count_q <= '0;
    end else if (res_valid_q) begin
      op_count_q <= op_count_q + 16'd1;
    end
  end

  assign op_count = op_count_q;
`else
  localparam bit STATS_EN = 1'b0;
`endif

endmodule

// File: tb/tb_logic16_rr_arbiter.sv
// Self-checking bench for logic16_rr_arbiter against a transaction-level round-robin model.
module tb_logic16_rr_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   m_ptr = NREQ - 1;
  int   m_count = 0;

  logic16_rr_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus_if ();

`ifdef LOGIC16_ARB_STATS_EN
  logic [15:0] op_count;
  logic16_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .op_count(op_count), .bus(bus_if.slave));
`else
  logic16_rr_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .bus(bus_if.slave));
`endif

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] r);
    for (int k = 1; k <= NREQ; k++)
      if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [WIDTH-1:0] f_op(input logic [1:0] opc,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    case (opc)
      2'b00:   return ~a;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int id);
    logic [NREQ-1:0] v;
    v = '0;
    v[id] = 1'b1;
    return v;
  endfunction

  task automatic check_count(input string name);
`ifdef LOGIC16_ARB_STATS_EN
    checks++;
    if (op_count !== 16'(m_count)) begin
      errors++;
      $display("FAIL %s op_count: got %0d expected %0d", name, op_count, m_count);
    end
`else
    if (name.len() < 0) errors++;
`endif
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_if.req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus_if.gnt !== 4'b0000 || bus_if.busy !== 1'b0 ||
          bus_if.res_valid !== 1'b0 || bus_if.res_data !== 16'h0000) begin
        errors++;
        $display("FAIL reset: gnt=%b busy=%b res_valid=%b res_data=%h expected 0000/0/0/0000",
                 bus_if.gnt, bus_if.busy, bus_if.res_valid, bus_if.res_data);
      end
    end
    m_ptr = NREQ - 1;
    m_count = 0;
    check_count("reset");
    reset = 1'b0;
    bus_if.req = '0;
    tick();
    checks++;
    if (bus_if.gnt !== 4'b0000 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: gnt=%b busy=%b expected 0000/0", bus_if.gnt, bus_if.busy);
    end
  endtask

  task automatic test_single_not();
    logic [15:0] ins [3]  = '{16'h1975, 16'hF975, 16'hFFFF};
    logic [15:0] outs [3] = '{16'hE68A, 16'h068A, 16'h0000};
    int id;
    for (int i = 0; i < 3; i++) begin
      bus_if.req = 4'b0001;
      bus_if.op_a[0 +: 16] = ins[i];
      bus_if.opcode[1:0] = 2'b00;
      id = rr_pick(m_ptr, bus_if.req);
      tick();
      checks++;
      if (bus_if.gnt !== onehot(id) || bus_if.res_valid !== 1'b0 || bus_if.busy !== 1'b1) begin
        errors++;
        $display("FAIL not_exec: gnt=%b res_valid=%b busy=%b expected %b/0/1",
                 bus_if.gnt, bus_if.res_valid, bus_if.busy, onehot(id));
      end
      tick();
      checks++;
      if (bus_if.gnt !== 4'b0001 || bus_if.res_valid !== 1'b1 ||
          bus_if.res_data !== outs[i] || bus_if.res_id !== 2'd0) begin
        errors++;
        $display("FAIL not_resp: gnt=%b valid=%b data=%h id=%0d expected 0001/1/%h/0",
                 bus_if.gnt, bus_if.res_valid, bus_if.res_data, bus_if.res_id, outs[i]);
      end
      bus_if.req = '0;
      m_ptr = id;
      m_count++;
      tick();
      checks++;
      if (bus_if.gnt !== 4'b0000 || bus_if.res_valid !== 1'b0 ||
          bus_if.busy !== 1'b0 || bus_if.res_data !== outs[i]) begin
        errors++;
        $display("FAIL not_after: gnt=%b valid=%b busy=%b data=%h expected 0000/0/0/%h",
                 bus_if.gnt, bus_if.res_valid, bus_if.busy, bus_if.res_data, outs[i]);
      end
    end
    check_count("single_not");
  endtask

  task automatic test_logic_ops();
    logic [15:0] outs [3] = '{16'h3030, 16'hFCFC, 16'hCCCC};
    for (int i = 0; i < 3; i++) begin
      bus_if.req = 4'b0100;
      bus_if.op_a[32 +: 16] = 16'hF0F0;
      bus_if.op_b[32 +: 16] = 16'h3C3C;
      bus_if.opcode[5:4] = 2'(i + 1);
      tick();
      checks++;
      if (bus_if.gnt !== 4'b0100) begin
        errors++;
        $display("FAIL ops_gnt: gnt=%b expected 0100", bus_if.gnt);
      end
      tick();
      checks++;
      if (bus_if.res_valid !== 1'b1 || bus_if.res_data !== outs[i] || bus_if.res_id !== 2'd2) begin
        errors++;
        $display("FAIL ops_result op=%0d: valid=%b data=%h id=%0d expected 1/%h/2",
                 i + 1, bus_if.res_valid, bus_if.res_data, bus_if.res_id, outs[i]);
      end
      bus_if.req = '0;
      m_ptr = 2;
      m_count++;
      tick();
    end
    check_count("logic_ops");
  endtask

  task automatic test_fairness();
    logic [15:0] a [NREQ];
    int n = 0;
    int last = 0;
    int id;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_ptr = NREQ - 1;
    m_count = 0;
    for (int i = 0; i < NREQ; i++) begin
      a[i] = 16'($urandom);
      bus_if.op_a[i*16 +: 16] = a[i];
    end
    bus_if.opcode = '0;
    bus_if.req = 4'b1111;
    for (int c = 0; c < 40 && n < 5; c++) begin
      tick();
      if (bus_if.res_valid === 1'b1) begin
        id = rr_pick(m_ptr, 4'b1111);
        m_ptr = id;
        m_count++;
        checks++;
        if (bus_if.res_id !== 2'(id) || bus_if.res_data !== ~a[id]) begin
          errors++;
          $display("FAIL fairness #%0d: id=%0d data=%h expected %0d/%h",
                   n, bus_if.res_id, bus_if.res_data, id, ~a[id]);
        end
        if (n > 0) begin
          checks++;
          if (cyc - last != 3) begin
            errors++;
            $display("FAIL fairness_spacing: %0d cycles expected 3", cyc - last);
          end
        end
        last = cyc;
        n++;
        if (n == 5) bus_if.req = '0;
      end
    end
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL fairness_timeout: saw %0d results expected 5", n);
    end
    tick();
    checks++;
    if (bus_if.busy !== 1'b0 || bus_if.gnt !== 4'b0000) begin
      errors++;
      $display("FAIL fairness_drain: busy=%b gnt=%b expected 0/0000", bus_if.busy, bus_if.gnt);
    end
    check_count("fairness");
  endtask

  task automatic test_mid_op();
    int id;
    bus_if.req = 4'b0010;
    bus_if.op_a[16 +: 16] = 16'h00FF;
    bus_if.op_b[16 +: 16] = 16'($urandom);
    bus_if.opcode[3:2] = 2'b00;
    id = rr_pick(m_ptr, bus_if.req);
    tick();
    checks++;
    if (bus_if.gnt !== onehot(id)) begin
      errors++;
      $display("FAIL midop_gnt: gnt=%b expected %b", bus_if.gnt, onehot(id));
    end
    bus_if.op_a[16 +: 16] = 16'hAAAA;
    bus_if.opcode[3:2] = 2'b11;
    bus_if.req = '0;
    tick();
    checks++;
    if (bus_if.res_valid !== 1'b1 || bus_if.res_data !== 16'hFF00 || bus_if.res_id !== 2'd1) begin
      errors++;
      $display("FAIL midop_result: valid=%b data=%h id=%0d expected 1/ff00/1",
               bus_if.res_valid, bus_if.res_data, bus_if.res_id);
    end
    m_ptr = id;
    m_count++;
    tick();
    check_count("mid_op");
  endtask

  task automatic test_reset_in_exec();
    logic [15:0] exp;
    bus_if.req = 4'b1000;
    tick();
    checks++;
    if (bus_if.gnt !== 4'b1000) begin
      errors++;
      $display("FAIL rexec_gnt: gnt=%b expected 1000", bus_if.gnt);
    end
    reset = 1'b1;
    bus_if.req = 4'b1001;
    tick();
    checks++;
    if (bus_if.gnt !== 4'b0000 || bus_if.res_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
      errors++;
      $display("FAIL rexec_abort: gnt=%b valid=%b busy=%b expected 0000/0/0",
               bus_if.gnt, bus_if.res_valid, bus_if.busy);
    end
    m_ptr = NREQ - 1;
    m_count = 0;
    check_count("reset_in_exec");
    reset = 1'b0;
    bus_if.op_a[0 +: 16] = 16'($urandom);
    bus_if.op_b[0 +: 16] = 16'($urandom);
    bus_if.opcode[1:0] = 2'($urandom);
    exp = f_op(bus_if.opcode[1:0], bus_if.op_a[0 +: 16], bus_if.op_b[0 +: 16]);
    tick();
    checks++;
    if (bus_if.gnt !== onehot(rr_pick(m_ptr, 4'b1001))) begin
      errors++;
      $display("FAIL rexec_regrant: gnt=%b expected 0001", bus_if.gnt);
    end
    tick();
    checks++;
    if (bus_if.res_valid !== 1'b1 || bus_if.res_id !== 2'd0 || bus_if.res_data !== exp) begin
      errors++;
      $display("FAIL rexec_result: valid=%b id=%0d data=%h expected 1/0/%h",
               bus_if.res_valid, bus_if.res_id, bus_if.res_data, exp);
    end
    bus_if.req = '0;
    m_ptr = 0;
    m_count++;
    tick();
    check_count("reset_in_exec_after");
  endtask

  task automatic test_random();
    logic [NREQ-1:0]       r;
    logic [NREQ*WIDTH-1:0] sa, sb;
    logic [NREQ*2-1:0]     so;
    logic [WIDTH-1:0]      exp;
    int id;
    for (int it = 0; it < 60; it++) begin
      r  = NREQ'($urandom_range(0, 15));
      sa = {$urandom, $urandom};
      sb = {$urandom, $urandom};
      so = 8'($urandom);
      bus_if.req = r; bus_if.op_a = sa; bus_if.op_b = sb; bus_if.opcode = so;
      tick();
      if (r == '0) begin
        checks++;
        if (bus_if.gnt !== '0 || bus_if.busy !== 1'b0) begin
          errors++;
          $display("FAIL rand_idle: gnt=%b busy=%b expected 0000/0", bus_if.gnt, bus_if.busy);
        end
        continue;
      end
      id  = rr_pick(m_ptr, r);
      exp = f_op(so[id*2 +: 2], sa[id*16 +: 16], sb[id*16 +: 16]);
      checks++;
      if (bus_if.gnt !== onehot(id)) begin
        errors++;
        $display("FAIL rand_gnt it=%0d: gnt=%b expected %b", it, bus_if.gnt, onehot(id));
      end
      bus_if.req = NREQ'($urandom);
      bus_if.op_a = {$urandom, $urandom};
      bus_if.opcode = 8'($urandom);
      tick();
      checks++;
      if (bus_if.res_valid !== 1'b1 || bus_if.res_id !== 2'(id) ||
          bus_if.res_data !== exp || bus_if.gnt !== onehot(id)) begin
        errors++;
        $display("FAIL rand_result it=%0d: valid=%b id=%0d data=%h gnt=%b expected 1/%0d/%h/%b",
                 it, bus_if.res_valid, bus_if.res_id, bus_if.res_data, bus_if.gnt, id, exp, onehot(id));
      end
      m_ptr = id;
      m_count++;
      tick();
      checks++;
      if (bus_if.res_valid !== 1'b0 || bus_if.busy !== 1'b0 ||
          bus_if.gnt !== '0 || bus_if.res_data !== exp) begin
        errors++;
        $display("FAIL rand_after it=%0d: valid=%b busy=%b gnt=%b data=%h expected 0/0/0000/%h",
                 it, bus_if.res_valid, bus_if.busy, bus_if.gnt, bus_if.res_data, exp);
      end
    end
    check_count("random");
  endtask

  initial begin
    reset = 1'b1;
    bus_if.req = '0;
    bus_if.op_a = '0;
    bus_if.op_b = '0;
    bus_if.opcode = '0;
    test_reset();
    test_single_not();
    test_logic_ops();
    test_fairness();
    test_mid_op();
    test_reset_in_exec();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
